simon_seq_engine: RTL

Parametrised pattern-memory game engine: loads a random symbol pattern, replays a growing prefix of it, checks player button presses against it, and reports pass/lose/win with a score. It sits between the button debouncers/random source and the seven-segment message mux. It generalises the fixed five-button, 50-step gameplay core to N symbols, configurable depth and timing, a single reset, and a clean win condition.

---
 rtl/simon_pkg.sv | 37 +++
 rtl/simon_tick_timer.sv | 30 +++
 rtl/simon_seq_engine.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/simon_pkg.sv
// Shared definitions for the Simon pattern-memory game engine: phase
// encodings, width helpers and the default symbol-index names.
package simon_pkg;

  // Nine phases need four bits; the phase port carries this encoding.
  localparam int unsigned PHASE_W = 4;

  localparam logic [PHASE_W-1:0] ST_IDLE     = 4'd0;
  localparam logic [PHASE_W-1:0] ST_LOAD     = 4'd1;
  localparam logic [PHASE_W-1:0] ST_SHOW_ON  = 4'd2;
  localparam logic [PHASE_W-1:0] ST_SHOW_OFF = 4'd3;
  localparam logic [PHASE_W-1:0] ST_INPUT    = 4'd4;
  localparam logic [PHASE_W-1:0] ST_RELEASE  = 4'd5;
  localparam logic [PHASE_W-1:0] ST_PASS     = 4'd6;
  localparam logic [PHASE_W-1:0] ST_LOSE     = 4'd7;
  localparam logic [PHASE_W-1:0] ST_WIN      = 4'd8;

  // Symbol indices of the classic five-button board.
  localparam int unsigned UP    = 0;
  localparam int unsigned DOWN  = 1;
  localparam int unsigned LEFT  = 2;
  localparam int unsigned RIGHT = 3;
  localparam int unsigned MID   = 4;

  function automatic int unsigned sym_width(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  function automatic int unsigned len_width(input int unsigned m);
    return (m < 1) ? 1 : $clog2(m + 1);
  endfunction

  function automatic int unsigned max_of(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/simon_tick_timer.sv
// Loadable down-counter advanced by the tick enable. done flags the tick
// that consumes the last remaining count, so a phase loaded with N lasts
// exactly N ticks (a load of 0 behaves like 1).
module simon_tick_timer #(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         tick,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         done
);

  logic [W-1:0] cnt_q;

  // Load wins over a coincident tick; count saturates at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (tick && (cnt_q != '0)) begin
      cnt_q <= cnt_q - W'(1);
    end
  end

  assign done = tick && (cnt_q <= W'(1));

endmodule

// File: rtl/simon_seq_engine.sv
// Simon gameplay core: loads a random pattern, replays a growing prefix,
// checks button presses and reports pass/lose/win with a score.
// Optional feature macro: SIMON_HISCORE_EN adds the hiscore register/port.
module simon_seq_engine
  import simon_pkg::*;
#(
  parameter int unsigned NUM_SYMS      = 5,
  parameter int unsigned MAX_LEN       = 50,
  parameter int unsigned START_LEN     = 5,
  parameter int unsigned SHOW_TICKS    = 2,
  parameter int unsigned GAP_TICKS     = 1,
  parameter int unsigned TIMEOUT_TICKS = 3,
  parameter int unsigned PASS_TICKS    = 2,
  localparam int unsigned SYM_W = sym_width(NUM_SYMS),
  localparam int unsigned LEN_W = len_width(MAX_LEN)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               tick,
  input  logic               start,
  input  logic [SYM_W-1:0]   rnd,
  input  logic [NUM_SYMS-1:0] btn,
  output logic [PHASE_W-1:0] phase,
  output logic               sym_valid,
  output logic [SYM_W-1:0]   sym,
  output logic [LEN_W-1:0]   round_len,
  output logic [LEN_W-1:0]   score
`ifdef SIMON_HISCORE_EN
  ,
  output logic [LEN_W-1:0]   hiscore
`endif
);

  localparam int unsigned IDX_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int unsigned TMR_W =
      len_width(max_of(max_of(SHOW_TICKS, GAP_TICKS), max_of(TIMEOUT_TICKS, PASS_TICKS)));
  localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);

  logic [PHASE_W-1:0] state_q, state_d;
  logic [LEN_W-1:0]   idx_q, idx_d;
  logic [LEN_W-1:0]   round_len_q, round_len_d;
  logic [LEN_W-1:0]   score_q, score_d;
  logic               sym_valid_q, sym_valid_d;
  logic [SYM_W-1:0]   sym_q, sym_d;
  logic [NUM_SYMS-1:0] btn_q;
  logic [SYM_W-1:0]   pat_q [MAX_LEN];

  logic               tmr_load, tmr_done;
  logic [TMR_W-1:0]   tmr_val;
  logic               pat_we;
  logic [SYM_W-1:0]   rnd_fold, pressed, cur_sym;
  logic               press, btn_one, last;

  simon_tick_timer #(.W(TMR_W)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .tick     (tick),
    .load     (tmr_load),
    .load_val (tmr_val),
    .done     (tmr_done)
  );

  // Press decode: rising edge of "any button", one-hot check, binary index.
  always_comb begin
    press    = (btn != '0) && (btn_q == '0);
    btn_one  = (btn != '0) && ((btn & (btn - NUM_SYMS'(1))) == '0);
    pressed  = '0;
    for (int i = 0; i < NUM_SYMS; i++) begin
      if (btn[i]) pressed = SYM_W'(i);
    end
    // rnd < 2*NUM_SYMS always, so one subtraction folds it into range.
    rnd_fold = (rnd >= SYM_W'(NUM_SYMS)) ? rnd - SYM_W'(NUM_SYMS) : rnd;
    cur_sym  = pat_q[idx_q[IDX_W-1:0]];
    last     = (idx_q == round_len_q - LEN_ONE);
  end

  // Next-state, counters, timer loads and registered-output next values.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    round_len_d = round_len_q;
    score_d     = score_q;
    tmr_load    = 1'b0;
    tmr_val     = '0;
    pat_we      = 1'b0;
    case (state_q)
      ST_IDLE, ST_LOSE, ST_WIN: begin
        if (start) begin
          state_d     = ST_LOAD;
          idx_d       = '0;
          score_d     = '0;
          round_len_d = LEN_W'(START_LEN);
        end
      end
      ST_LOAD: begin
        pat_we = 1'b1;
        if (idx_q == LEN_W'(MAX_LEN - 1)) begin
          state_d  = ST_SHOW_ON;
          idx_d    = '0;
          tmr_load = 1'b1;
          tmr_val  = TMR_W'(SHOW_TICKS);
        end else begin
          idx_d = idx_q + LEN_ONE;
        end
      end
      ST_SHOW_ON: begin
        if (tmr_done) begin
          state_d  = ST_SHOW_OFF;
          tmr_load = 1'b1;
          tmr_val  = TMR_W'(GAP_TICKS);
        end
      end
      ST_SHOW_OFF: begin
        if (tmr_done) begin
          tmr_load = 1'b1;
          if (last) begin
            state_d = ST_INPUT;
            idx_d   = '0;
            tmr_val = TMR_W'(TIMEOUT_TICKS);
          end else begin
            state_d = ST_SHOW_ON;
            idx_d   = idx_q + LEN_ONE;
            tmr_val = TMR_W'(SHOW_TICKS);
          end
        end
      end
      ST_INPUT: begin
        // A press outranks a timeout expiring on the same tick.
        if (press) begin
          state_d = (btn_one && (pressed == cur_sym)) ? ST_RELEASE : ST_LOSE;
        end else if (tmr_done) begin
          state_d = ST_LOSE;
        end
      end
      ST_RELEASE: begin
        if (btn == '0) begin
          tmr_load = 1'b1;
          if (last) begin
            state_d = ST_PASS;
            score_d = score_q + LEN_ONE;
            tmr_val = TMR_W'(PASS_TICKS);
          end else begin
            state_d = ST_INPUT;
            idx_d   = idx_q + LEN_ONE;
            tmr_val = TMR_W'(TIMEOUT_TICKS);
          end
        end
      end
      ST_PASS: begin
        if (tmr_done) begin
          if (round_len_q == LEN_W'(MAX_LEN)) begin
            state_d = ST_WIN;
          end else begin
            state_d     = ST_SHOW_ON;
            round_len_d = round_len_q + LEN_ONE;
            idx_d       = '0;
            tmr_load    = 1'b1;
            tmr_val     = TMR_W'(SHOW_TICKS);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    sym_valid_d = (state_d == ST_SHOW_ON) || (state_d == ST_RELEASE);
    sym_d       = sym_q;
    if (state_d == ST_SHOW_ON) begin
      sym_d = pat_q[idx_d[IDX_W-1:0]];
    end else if ((state_q == ST_INPUT) && (state_d == ST_RELEASE)) begin
      sym_d = pressed;
    end
  end

  // Control state and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      round_len_q <= '0;
      score_q     <= '0;
      sym_valid_q <= 1'b0;
      sym_q       <= '0;
      btn_q       <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      round_len_q <= round_len_d;
      score_q     <= score_d;
      sym_valid_q <= sym_valid_d;
      sym_q       <= sym_d;
      btn_q       <= btn;
    end
  end

  // Pattern storage; contents are don't-care until the first load.
  always_ff @(posedge clk) begin
    if (pat_we) pat_q[idx_q[IDX_W-1:0]] <= rnd_fold;
  end

`ifdef SIMON_HISCORE_EN
  logic [LEN_W-1:0] hiscore_q;

  // Best score, captured when a game ends; only rst_n clears it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hiscore_q <= '0;
    end else if (((state_d == ST_LOSE) || (state_d == ST_WIN)) && (state_d != state_q) &&
                 (score_q > hiscore_q)) begin
      hiscore_q <= score_q;
    end
  end

  assign hiscore = hiscore_q;
`endif

  assign phase     = state_q;
  assign sym_valid = sym_valid_q;
  assign sym       = sym_q;
  assign round_len = round_len_q;
  assign score     = score_q;

endmodule
